// File: rtl/wb_cmd_master.sv
// Wishbone B4 classic initiator: turns one ready/valid command into one single
// read/write bus cycle and returns read data or a timeout error as a response.
module wb_cmd_master #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [1:0]      state_reg;
    logic [TO_W-1:0] to_cnt_reg;
    logic            cyc_reg;
    logic            we_reg;
    logic [3:0]      sel_reg;
    logic [31:0]     adr_reg;
    logic [31:0]     dat_reg;
    logic [31:0]     rsp_dat_reg;
    logic            rsp_err_reg;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg   <= IDLE;
            to_cnt_reg  <= '0;
            cyc_reg     <= 1'b0;
            we_reg      <= 1'b0;
            sel_reg     <= '0;
            adr_reg     <= '0;
            dat_reg     <= '0;
            rsp_dat_reg <= '0;
            rsp_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        we_reg     <= cmd_we;
                        sel_reg    <= cmd_sel;
                        adr_reg    <= cmd_adr;
                        dat_reg    <= cmd_dat;
                        cyc_reg    <= 1'b1;
                        to_cnt_reg <= '0;
                        state_reg  <= BUS;
                    end
                end
                BUS: begin
                    // ACK takes priority over a timeout landing on the same cycle
                    if (wbm_ack_i) begin
                        cyc_reg     <= 1'b0;
                        we_reg      <= 1'b0;
                        rsp_dat_reg <= we_reg ? 32'd0 : wbm_dat_i;
                        rsp_err_reg <= 1'b0;
                        state_reg   <= RESP;
                    end else if (to_cnt_reg == TO_LAST) begin
                        cyc_reg     <= 1'b0;
                        we_reg      <= 1'b0;
                        rsp_dat_reg <= 32'd0;
                        rsp_err_reg <= 1'b1;
                        state_reg   <= RESP;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign busy      = (state_reg != IDLE);
    assign rsp_dat   = rsp_dat_reg;
    assign rsp_err   = rsp_err_reg;
    assign wbm_cyc_o = cyc_reg;
    assign wbm_stb_o = cyc_reg;
    assign wbm_we_o  = we_reg;
    assign wbm_sel_o = sel_reg;
    assign wbm_adr_o = adr_reg;
    assign wbm_dat_o = dat_reg;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed plan cases plus randomized
// transactions compared against a per-transaction outcome model.
module tb_wb_cmd_master;

    localparam int TIMEOUT = 8;
    localparam int TO_W    = 8;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int txn_no = 0;

    wb_cmd_master #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (wb_rst_i),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=0x%08h expected=0x%08h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full command/bus/response sequence. ack_delay = number of wait
    // states before the slave ACKs; anything >= TIMEOUT means it never does.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int ack_delay,
                           input logic [31:0] rdata, input int rsp_delay, input bit hold_cmd);
        int          cyc_cnt;
        int          exp_cyc;
        logic        exp_err;
        logic [31:0] exp_dat;

        if (ack_delay >= 0 && ack_delay < TIMEOUT) begin
            exp_cyc = ack_delay + 1;
            exp_err = 1'b0;
            exp_dat = we ? 32'd0 : rdata;
        end else begin
            exp_cyc = TIMEOUT;
            exp_err = 1'b1;
            exp_dat = 32'd0;
        end

        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        next_cycle();
        cmd_valid = 1'b0;
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        cmd_sel   = 4'($urandom);
        cmd_we    = ~we;

        cyc_cnt = 0;
        while (wbm_cyc_o && cyc_cnt < 4 * TIMEOUT) begin
            check("bus_stb", 32'(wbm_stb_o), 32'd1);
            check("bus_we", 32'(wbm_we_o), 32'(we));
            check("bus_adr", wbm_adr_o, adr);
            check("bus_dat", wbm_dat_o, dat);
            check("bus_sel", 32'(wbm_sel_o), 32'(sel));
            check("bus_cmd_ready", 32'(cmd_ready), 32'd0);
            wbm_ack_i = (cyc_cnt == ack_delay);
            wbm_dat_i = wbm_ack_i ? rdata : $urandom;
            cyc_cnt++;
            next_cycle();
        end
        wbm_ack_i = 1'b0;
        wbm_dat_i = $urandom;
        check("cyc_len", 32'(cyc_cnt), 32'(exp_cyc));
        check("post_stb", 32'(wbm_stb_o), 32'd0);
        check("post_we", 32'(wbm_we_o), 32'd0);
        check("post_adr_kept", wbm_adr_o, adr);

        for (int i = 0; i <= rsp_delay; i++) begin
            check("rsp_valid", 32'(rsp_valid), 32'd1);
            check("rsp_dat", rsp_dat, exp_dat);
            check("rsp_err", 32'(rsp_err), 32'(exp_err));
            check("rsp_busy", 32'(busy), 32'd1);
            check("rsp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("rsp_cyc", 32'(wbm_cyc_o), 32'd0);
            if (hold_cmd) cmd_valid = 1'b1;
            rsp_ready = (i == rsp_delay);
            next_cycle();
        end
        rsp_ready = 1'b0;
        check("after_rsp_valid", 32'(rsp_valid), 32'd0);
        check("after_cmd_ready", 32'(cmd_ready), 32'd1);
        check("after_no_same_cycle_accept", 32'(wbm_cyc_o), 32'd0);
        cmd_valid = 1'b0;

        txn_no++;
        $display("[TB] txn %0d we=%0d adr=%08h sel=%h ack_delay=%0d cyc=%0d err=%0d rsp_dat=%08h",
                 txn_no, we, adr, sel, ack_delay, cyc_cnt, exp_err, exp_dat);
    endtask

    initial begin
        wb_rst_i  = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = 32'd0;
        cmd_dat   = 32'd0;
        cmd_sel   = 4'd0;
        rsp_ready = 1'b0;
        wbm_dat_i = 32'd0;
        wbm_ack_i = 1'b0;
        repeat (3) next_cycle();
        wb_rst_i = 1'b0;

        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_dat", rsp_dat, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        check("rst_adr", wbm_adr_o, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Directed plan cases
        run_txn(1'b1, 32'h3000_0004, 32'h0000_00FF, 4'hF, 0, 32'h0, 0, 1'b0);
        run_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 3, 32'hA5A5_1234, 0, 1'b0);
        run_txn(1'b0, 32'h3000_0008, 32'h0, 4'h3, TIMEOUT + 5, 32'hDEAD_BEEF, 0, 1'b0);
        run_txn(1'b0, 32'h3000_000C, 32'h0, 4'hC, TIMEOUT - 1, 32'h1357_9BDF, 0, 1'b0);
        run_txn(1'b1, 32'h3000_0010, 32'h1234_5678, 4'h1, 1, 32'h0, 5, 1'b1);

        // Reset on the second BUS cycle, followed by a late ACK
        cmd_we    = 1'b1;
        cmd_adr   = 32'h3000_0020;
        cmd_dat   = 32'hCAFE_F00D;
        cmd_sel   = 4'hF;
        cmd_valid = 1'b1;
        next_cycle();
        cmd_valid = 1'b0;
        next_cycle();
        check("pre_rst_cyc", 32'(wbm_cyc_o), 32'd1);
        wb_rst_i = 1'b1;
        next_cycle();
        wb_rst_i = 1'b0;
        check("midrst_cyc", 32'(wbm_cyc_o), 32'd0);
        check("midrst_stb", 32'(wbm_stb_o), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst_adr", wbm_adr_o, 32'd0);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h5555_AAAA;
        next_cycle();
        wbm_ack_i = 1'b0;
        next_cycle();
        check("late_ack_rsp_valid", 32'(rsp_valid), 32'd0);
        check("late_ack_busy", 32'(busy), 32'd0);

        // Spurious ACK in IDLE, with rsp_ready held high
        rsp_ready = 1'b1;
        wbm_ack_i = 1'b1;
        next_cycle();
        wbm_ack_i = 1'b0;
        next_cycle();
        rsp_ready = 1'b0;
        check("spur_rsp_valid", 32'(rsp_valid), 32'd0);
        check("spur_busy", 32'(busy), 32'd0);
        check("spur_cmd_ready", 32'(cmd_ready), 32'd1);
        check("spur_cyc", 32'(wbm_cyc_o), 32'd0);

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            run_txn(1'($urandom), 32'($urandom), 32'($urandom), 4'($urandom),
                    int'($urandom_range(0, TIMEOUT + 2)), 32'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
